// File: rtl/wb_select_pipe_if.sv
// Writeback stage bus: MEM-stage instruction in, long-latency result in,
// register-file write port and status out.
//   slave  modport : used by wb_select_pipe
//   master modport : used by whatever drives the stage (MEM stage / bench)
// Signals:
//   flush                 drop accepted/pending instruction
//   in_valid / in_ready   instruction handshake
//   in_src                0 ALU, 1 MEM load, 2 LINK, 3 NONE
//   in_regf               destination register
//   in_data_a / in_data_b ALU result / raw aligned memory word
//   in_pc                 instruction PC
//   in_ld_size/sign/ofs   load size, sign-extend flag, byte offset
//   in_wait_ext           result arrives later on ext_data
//   ext_valid / ext_data  long-latency result
//   rd_we/rd_regf/rd_data register-file write port
//   busy                  waiting for a long-latency result
interface wb_select_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REGF_W = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_src;
  logic [REGF_W-1:0] in_regf;
  logic [DATA_W-1:0] in_data_a;
  logic [DATA_W-1:0] in_data_b;
  logic [ADDR_W-1:0] in_pc;
  logic [1:0]        in_ld_size;
  logic              in_ld_sign;
  logic [1:0]        in_ld_ofs;
  logic              in_wait_ext;
  logic              ext_valid;
  logic [DATA_W-1:0] ext_data;
  logic              rd_we;
  logic [REGF_W-1:0] rd_regf;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport slave (
    input  flush, in_valid, in_src, in_regf, in_data_a, in_data_b, in_pc,
           in_ld_size, in_ld_sign, in_ld_ofs, in_wait_ext, ext_valid, ext_data,
    output in_ready, rd_we, rd_regf, rd_data, busy
  );

  modport master (
    output flush, in_valid, in_src, in_regf, in_data_a, in_data_b, in_pc,
           in_ld_size, in_ld_sign, in_ld_ofs, in_wait_ext, ext_valid, ext_data,
    input  in_ready, rd_we, rd_regf, rd_data, busy
  );
endinterface

// File: rtl/wb_select_pipe.sv
// Registered writeback stage. Chooses ALU result, extended load data or the
// link address and writes it to the register file one cycle after accept.
// Instructions flagged in_wait_ext park in WAIT until ext_valid delivers the
// long-latency result, which is then written with the latched destination.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active high
//   bus  wb_select_pipe_if.slave (handshake, operands, write port, busy)
module wb_select_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REGF_W   = 5,
  parameter int LINK_OFS = 8
) (
  input logic             clk,
  input logic             rst,
  wb_select_pipe_if.slave bus
);

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_we_p1;
  logic [REGF_W-1:0] r_regf_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic              r_busy_p1;
  logic [REGF_W-1:0] r_pend_regf;

  // Byte/half/word select from the aligned memory word plus extension.
  function automatic logic [DATA_W-1:0] ld_extend(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic              sgn,
    input logic [1:0]        ofs
  );
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{ofs, 3'b000} +: 8];
    h = word[{ofs[1], 4'b0000} +: 16];
    case (size)
      2'd0:    ld_extend = sgn ? DATA_W'(b) : DATA_W'($unsigned(b));
      2'd1:    ld_extend = sgn ? DATA_W'(h) : DATA_W'($unsigned(h));
      default: ld_extend = word;
    endcase
  endfunction

  // Return address past the delay slot; sum wraps at ADDR_W before widening.
  function automatic logic [DATA_W-1:0] link_addr(input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-1:0] s;
    s = pc + ADDR_W'(LINK_OFS);
    link_addr = DATA_W'(s);
  endfunction

  assign bus.in_ready = (r_state == S_IDLE);
  assign w_accept     = bus.in_valid & (r_state == S_IDLE) & ~bus.flush;

  always_comb begin
    w_sel_data = bus.in_data_a;
    case (bus.in_src)
      SRC_ALU:  w_sel_data = bus.in_data_a;
      SRC_MEM:  w_sel_data = ld_extend(bus.in_data_b, bus.in_ld_size,
                                       bus.in_ld_sign, bus.in_ld_ofs);
      SRC_LINK: w_sel_data = link_addr(bus.in_pc);
      default:  w_sel_data = bus.in_data_a;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && bus.in_wait_ext) w_state_nxt = S_WAIT;
        S_WAIT:  if (bus.ext_valid) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Stage p1: write port register. Data/index only move when something is
  // selected for writing, so they hold between pulses. A zero destination
  // still updates the index; only the enable is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_p1   <= 1'b0;
      r_regf_p1 <= '0;
      r_data_p1 <= '0;
      r_busy_p1 <= 1'b0;
    end else begin
      r_we_p1   <= 1'b0;
      r_busy_p1 <= (w_state_nxt == S_WAIT);
      if (!bus.flush) begin
        if (w_accept) begin
          if (!bus.in_wait_ext && bus.in_src != SRC_NONE) begin
            r_we_p1   <= (bus.in_regf != '0);
            r_regf_p1 <= bus.in_regf;
            r_data_p1 <= w_sel_data;
          end
        end else if (r_state == S_WAIT && bus.ext_valid) begin
          r_we_p1   <= (r_pend_regf != '0);
          r_regf_p1 <= r_pend_regf;
          r_data_p1 <= bus.ext_data;
        end
      end
    end
  end

  // Destination of the parked long-latency instruction.
  always_ff @(posedge clk) begin
    if (w_accept && bus.in_wait_ext) r_pend_regf <= bus.in_regf;
  end

  assign bus.rd_we   = r_we_p1;
  assign bus.rd_regf = r_regf_p1;
  assign bus.rd_data = r_data_p1;
  assign bus.busy    = r_busy_p1;

endmodule

// File: tb/tb_wb_select_pipe.sv
module tb_wb_select_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_select_pipe_if #(.DATA_W(32), .ADDR_W(32), .REGF_W(5)) bus ();

  wb_select_pipe #(.DATA_W(32), .ADDR_W(32), .REGF_W(5), .LINK_OFS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   cmp = 0;
  int   bad = 0;
  bit   mon_en = 0;
  bit   m_wait = 0;
  logic [4:0] m_pend = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: load extraction by shifting and masking the word.
  function automatic logic [31:0] m_load(input logic [31:0] w, input int size,
                                         input bit sgn, input int ofs);
    logic [31:0] v;
    if (size >= 2) return w;
    if (size == 0) begin
      v = (w >> (8 * ofs)) & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> (16 * (ofs / 2))) & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_value();
    case (bus.in_src)
      2'd0:    return bus.in_data_a;
      2'd1:    return m_load(bus.in_data_b, int'(bus.in_ld_size), bus.in_ld_sign,
                             int'(bus.in_ld_ofs));
      default: return bus.in_pc + 32'd8;
    endcase
  endfunction

  // Apply the model to the inputs presently driven, then advance one clock.
  task automatic tick();
    bit nxt;
    nxt = m_wait;
    if (rst || bus.flush) begin
      nxt = 0;
    end else if (!m_wait) begin
      if (bus.in_valid) begin
        if (bus.in_wait_ext) begin
          nxt = 1;
          m_pend = bus.in_regf;
        end else if (bus.in_src != 2'd3 && bus.in_regf != 5'd0) begin
          q.push_back('{r: bus.in_regf, d: m_value()});
        end
      end
    end else if (bus.ext_valid) begin
      if (m_pend != 5'd0) q.push_back('{r: m_pend, d: bus.ext_data});
      nxt = 0;
    end
    @(posedge clk);
    m_wait = nxt;
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_src = 0; bus.in_regf = 0; bus.in_data_a = 0;
    bus.in_data_b = 0; bus.in_pc = 0; bus.in_ld_size = 0; bus.in_ld_sign = 0;
    bus.in_ld_ofs = 0; bus.in_wait_ext = 0; bus.flush = 0;
    bus.ext_valid = 0; bus.ext_data = 0;
  endtask

  task automatic put(input logic [1:0] src, input logic [4:0] regf,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                     input logic [1:0] sz, input logic sg, input logic [1:0] ofs,
                     input logic wx);
    bus.in_valid = 1; bus.in_src = src; bus.in_regf = regf; bus.in_data_a = a;
    bus.in_data_b = b; bus.in_pc = pc; bus.in_ld_size = sz; bus.in_ld_sign = sg;
    bus.in_ld_ofs = ofs; bus.in_wait_ext = wx;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".rd_we"},    32'(bus.rd_we),   32'd0);
    chk({nm, ".rd_regf"},  32'(bus.rd_regf), 32'd0);
    chk({nm, ".rd_data"},  bus.rd_data,      32'd0);
    chk({nm, ".busy"},     32'(bus.busy),    32'd0);
    chk({nm, ".in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Monitor: status every cycle, write port against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!m_wait));
      chk("busy", 32'(bus.busy), 32'(m_wait));
      if (bus.rd_we === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_write", 32'(bus.rd_regf), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rd_regf", 32'(bus.rd_regf), 32'(e.r));
          chk("rd_data", bus.rd_data, e.d);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    chk_zero("reset");
    rst = 0;
    mon_en = 1;

    put(0, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0); tick(); idle(); tick();
    put(1, 3, 0, 32'h0080_0000, 0, 0, 1, 2, 0); tick();
    put(1, 4, 0, 32'h0080_0000, 0, 0, 0, 2, 0); tick();
    put(1, 6, 0, 32'h8001_7F02, 0, 1, 1, 3, 0); tick();
    put(1, 7, 0, 32'hCAFE_F00D, 0, 2, 1, 1, 0); tick();
    put(2, 31, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0); tick();
    put(2, 0, 0, 0, 32'h0000_1000, 0, 0, 0, 0); tick();
    put(3, 7, 32'h5555_5555, 0, 0, 0, 0, 0, 0); tick();
    idle(); tick();

    put(0, 9, 0, 0, 0, 0, 0, 0, 1); bus.ext_valid = 1; bus.ext_data = 32'h1111_1111;
    tick(); idle();
    tick(); tick(); tick();
    bus.ext_valid = 1; bus.ext_data = 32'hDEAD_BEEF; tick(); idle(); tick();

    put(0, 10, 0, 0, 0, 0, 0, 0, 1); tick(); idle(); tick();
    bus.flush = 1; tick(); idle();
    bus.ext_valid = 1; bus.ext_data = 32'h2222_2222; tick(); idle(); tick();
    put(0, 11, 32'h3333_3333, 0, 0, 0, 0, 0, 0); bus.flush = 1; tick(); idle(); tick();

    for (int i = 0; i < 8; i++) begin
      put(0, 5'(i + 1), $urandom, 0, 0, 0, 0, 0, 0); tick();
    end
    rst = 1; idle(); tick();
    chk_zero("rst_stream");
    rst = 0;
    put(0, 12, 0, 0, 0, 0, 0, 0, 1); tick(); idle(); tick();
    rst = 1; tick();
    chk_zero("rst_wait");
    rst = 0; tick();

    for (int i = 0; i < 3000; i++) begin
      logic wx;
      logic [4:0] rf;
      idle();
      wx = ($urandom_range(0, 4) == 0);
      rf = 5'($urandom);
      if (wx && rf == 0) rf = 5'd1;
      if ($urandom_range(0, 9) < 7)
        put(2'($urandom), rf, $urandom, $urandom, $urandom,
            2'($urandom), 1'($urandom), 2'($urandom), wx);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.ext_valid = ($urandom_range(0, 2) == 0);
      bus.ext_data  = $urandom;
      rst           = ($urandom_range(0, 199) == 0);
      tick();
      rst = 0;
    end

    idle(); bus.flush = 1; tick(); idle(); tick(); tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
